// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: one req/resp access per EX/MEM instruction, aligned load formatting.
// Optional build macro MEM_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into a flagged no-op.
module mem_stage_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_data,
    input  logic [31:0] ex_rs2_data,
    input  logic        flush,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_byte_enable,
    output logic [31:0] dmem_wdata,
    output logic        stall,
    output logic        mem_done,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalign_err,
`endif
    output logic [31:0] wb_data,
    output logic        wb_valid
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] addr_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] rs2_reg;
    logic        write_reg;
    logic        squash_reg;
    logic        trap_reg;
    logic        req_read_reg;
    logic        req_write_reg;
    logic        done_reg;
    logic [31:0] wb_data_reg;

    logic        take_op;
    logic        trap_next;
    logic [1:0]  off;
    logic        st_byte;
    logic        st_half;
    logic        ld_byte;
    logic        ld_half;
    logic        ld_signed;
    logic [15:0] rdata_shift;
    logic [31:0] load_fmt;
    logic [3:0]  be_lanes;
    logic [31:0] wdata_lanes;

    assign take_op = ex_valid & (ex_mem_read | ex_mem_write) & ~flush;

`ifdef MEM_MISALIGN_TRAP_EN
    logic in_byte;
    logic in_half;

    // Store and load funct3 decode differ: a store with funct3=100 is a word, a load is LBU.
    assign in_byte   = ex_mem_write ? (ex_funct3 == 3'b000) : (ex_funct3[1:0] == 2'b00);
    assign in_half   = ex_mem_write ? (ex_funct3 == 3'b001) : (ex_funct3[1:0] == 2'b01);
    assign trap_next = in_half ? ex_alu_data[0]
                               : (~in_byte & (ex_alu_data[1:0] != 2'b00));
    assign misalign_err = done_reg & trap_reg;
`else
    assign trap_next = 1'b0;
`endif

    assign off       = addr_reg[1:0];
    assign st_byte   = (funct3_reg == 3'b000);
    assign st_half   = (funct3_reg == 3'b001);
    assign ld_byte   = (funct3_reg[1:0] == 2'b00);
    assign ld_half   = (funct3_reg[1:0] == 2'b01);
    assign ld_signed = ~funct3_reg[2];

    // Per-lane store data replication and byte enables; a halfword at offset 3 keeps only lane 3.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_lanes[8*gi +: 8] = st_byte ? rs2_reg[7:0] :
                                            st_half ? rs2_reg[8*(gi%2) +: 8] :
                                                      rs2_reg[8*gi +: 8];
            assign be_lanes[gi] = st_byte ? (off == 2'(gi)) :
                                  st_half ? ((off == 2'(gi)) | (({1'b0, off} + 3'd1) == 3'(gi))) :
                                            1'b1;
        end
    endgenerate

    // Shifting right pulls zeros into lanes past byte 3 before extension.
    assign rdata_shift = 16'(dmem_rdata >> {off, 3'b000});

    always_comb begin
        load_fmt = dmem_rdata;
        if (ld_byte) begin
            load_fmt = {{24{ld_signed & rdata_shift[7]}}, rdata_shift[7:0]};
        end else if (ld_half) begin
            load_fmt = {{16{ld_signed & rdata_shift[15]}}, rdata_shift[15:0]};
        end
    end

    always_comb begin
        stall = 1'b0;
        case (state_reg)
            S_IDLE:   stall = take_op;
            S_ACCESS: stall = 1'b1;
            default:  stall = 1'b0;
        endcase
    end

    assign dmem_read        = req_read_reg;
    assign dmem_write       = req_write_reg;
    assign dmem_addr        = {addr_reg[31:2], 2'b00};
    assign dmem_byte_enable = write_reg ? be_lanes : 4'b0000;
    assign dmem_wdata       = wdata_lanes;
    assign mem_done         = done_reg;
    assign wb_data          = wb_data_reg;
    // A flush arriving in the retire cycle still kills the writeback.
    assign wb_valid         = done_reg & ~write_reg & ~squash_reg & ~trap_reg & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            funct3_reg    <= '0;
            rs2_reg       <= '0;
            write_reg     <= 1'b0;
            squash_reg    <= 1'b0;
            trap_reg      <= 1'b0;
            req_read_reg  <= 1'b0;
            req_write_reg <= 1'b0;
            done_reg      <= 1'b0;
            wb_data_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (take_op) begin
                        addr_reg   <= ex_alu_data;
                        funct3_reg <= ex_funct3;
                        rs2_reg    <= ex_rs2_data;
                        write_reg  <= ex_mem_write;
                        squash_reg <= 1'b0;
                        trap_reg   <= trap_next;
                        if (trap_next) begin
                            wb_data_reg <= '0;
                            done_reg    <= 1'b1;
                            state_reg   <= S_DONE;
                        end else begin
                            req_read_reg  <= ~ex_mem_write;
                            req_write_reg <= ex_mem_write;
                            state_reg     <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    // Memory has already committed, so a flush only marks the result dead.
                    if (flush) begin
                        squash_reg <= 1'b1;
                    end
                    if (dmem_resp) begin
                        wb_data_reg   <= write_reg ? 32'd0 : load_fmt;
                        req_read_reg  <= 1'b0;
                        req_write_reg <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    req_read_reg  <= 1'b0;
                    req_write_reg <= 1'b0;
                    done_reg      <= 1'b0;
                    state_reg     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Consumer side of the EX/MEM pipeline latch in the RV32I pipeline.
- Takes the latched ALU result as the address, rs2 as store data, and the memory control fields. Drives one data-memory transaction with a req/resp handshake.
- Holds the EX/MEM latch via `stall` while the access is outstanding.
- Produces the aligned, sign/zero-extended load result for MEM/WB.

Parameters:
- None.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX/MEM latch holds a live instruction
- ex_mem_read  in  1  load instruction (from latched ctrl word)
- ex_mem_write  in  1  store instruction (from latched ctrl word)
- ex_funct3  in  3  access size/sign, RV32I encoding
- ex_alu_data  in  32  effective byte address
- ex_rs2_data  in  32  store source
- flush  in  1  squash current MEM instruction
- dmem_resp  in  1  memory completes access this cycle
- dmem_rdata  in  32  read word, valid with dmem_resp
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_byte_enable  out  4  write byte lanes
- dmem_wdata  out  32  lane-replicated store data
- stall  out  1  hold EX/MEM latch and upstream (latch_enable = ~stall)
- mem_done  out  1  one-cycle pulse, access retired
- wb_data  out  32  formatted load result
- wb_valid  out  1  wb_data valid this cycle (loads only)

Behaviour:
- **States:** IDLE, ACCESS, DONE. Reset (async, rst_n = 0) forces IDLE.
- **Reset values:** all outputs 0, except `stall`, which is the combinational IDLE term below and may be 1 during reset if a memory op is presented.
- **IDLE:**
  - `stall = ex_valid & (ex_mem_read | ex_mem_write) & ~flush`.
  - When that term is 1, capture address, funct3, rs2 and the read/write flag into internal registers, then go to ACCESS next edge.
  - Non-memory or flushed instructions pass with no stall and no access.
  - If both read and write are set, write takes priority.
- **ACCESS:**
  - `dmem_read` or `dmem_write` = 1, driven from the captured registers and held stable until `dmem_resp`.
  - `stall = 1`.
  - On `dmem_resp`: register the formatted load result into `wb_data`, then go to DONE.
  - Minimum latency: request visible 1 cycle after the instruction appears; retire 1 cycle after `dmem_resp`.
- **DONE:**
  - `stall = 0`, `mem_done = 1`, `wb_valid = 1` if load and not squashed.
  - The latch advances at the end of this cycle. Next state is IDLE.
  - An instruction arriving immediately afterwards is evaluated in IDLE on the following cycle (no back-to-back overlap).
- **Flush:**
  - In IDLE, flush suppresses the access.
  - In ACCESS, the transaction is not aborted (memory already committed). A sticky `squash` flag is set, and DONE then gives `wb_valid = 0`; `mem_done` still pulses.
  - flush in DONE has the same effect on `wb_valid`.
- **Address:** `dmem_addr = {addr[31:2], 2'b00}`; `off = addr[1:0]`.
- **Stores:**
  - SB (000): `wdata = {4{rs2[7:0]}}`, `be = 4'b0001 << off`.
  - SH (001): `wdata = {2{rs2[15:0]}}`, `be = 4'b0011 << off`, truncated to 4 bits; off = 3 gives 1000.
  - SW (010): `wdata = rs2`, `be = 1111`.
  - Other funct3 values are treated as SW.
  - `be` is 0 for reads.
- **Loads:**
  - LB (000): sign-extend byte `off`.
  - LBU (100): zero-extend byte `off`.
  - LH (001): sign-extend halfword at bytes `off` and `off+1`. Lanes beyond byte 3 read as 0 before extension.
  - LHU (101): as LH, zero-extended.
  - LW and others: full word.
- Misaligned accesses are performed as specified above, with no trap (default).

Optional Feature:
- **Macro:** `MEM_MISALIGN_TRAP_EN`.
- **When defined:**
  - Adds output `misalign_err` (1 bit).
  - A halfword with `off[0] = 1`, or a word with `off != 0`, issues no memory request. The block goes IDLE → DONE directly (stall 1 cycle), with `wb_data = 0`, `wb_valid = 0` and `misalign_err = 1` for the DONE cycle.
- **When undefined:** the port is absent and misaligned accesses behave as in Behaviour.

Test Plan:
- **LW, aligned:** LW addr 0x1000, resp after 3 cycles, rdata 0xDEADBEEF → `dmem_addr` 0x1000, `stall` high 5 cycles, `wb_data` 0xDEADBEEF, one `wb_valid` pulse.
- **Sub-word loads:** LB addr 0x1003, rdata 0x80FF1234 → `wb_data` 0xFFFFFF80; LBU at the same address → 0x00000080; LHU addr 0x1002 → 0x000080FF.
- **Sub-word stores:** SB addr 0x2001, rs2 0x000000AB → be 0010, wdata 0xABABABAB. SH addr 0x2002, rs2 0x1234 → be 1100, wdata 0x12341234.
- **Flush during ACCESS:** flush asserted while a load is in ACCESS → read held until resp, `mem_done` pulses, `wb_valid` stays 0. Flush in IDLE with a store → no `dmem_write`, no stall.
- **Reset mid-access:** rst_n low during ACCESS → immediately `dmem_read = 0`, state IDLE; after release, the next op starts cleanly.
- **`MEM_MISALIGN_TRAP_EN` defined:** LW addr 0x1001 → no `dmem_read`, `stall` 1 cycle, `misalign_err` 1 cycle, `wb_valid` 0.
